riscv_dext_queue: RTL and testbench
===================================

# riscv_dext_queue

Data external access logic for the RISC-V core, placed between the data cache/LSU and the AHB-Lite bus interface unit (BIU). It buffers up to QDEPTH CPU data requests in a FIFO and issues them to the BIU, limiting outstanding transfers to DEPTH. It forwards responses back to the CPU and discards responses that belong to requests flushed by `clr_i`. With the error-latch option compiled in, it also records the address of the first failed transfer.

## Interface
- XLEN, 64, data width
- PLEN, 64, physical address width
- QDEPTH, 4, request FIFO entries (power of 2, >=2)
- DEPTH, 2, maximum BIU transfers in flight (>=1)
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- clr_i  in  1  flush: drop queued requests, discard outstanding responses
- mem_req_i  in  1  CPU request valid
- mem_adr_i  in  XLEN  request address
- mem_size_i / mem_type_i / mem_prot_i  in  3 each  transfer size, burst type, protection
- mem_lock_i, mem_we_i  in  1 each  locked transfer, write enable
- mem_d_i  in  XLEN  write data
- mem_adr_ack_o  out  1  request accepted (queued or issued)
- mem_rdy_o  out  1  FIFO not full
- mem_adr_o  out  PLEN  BIU address-phase address (pass-through of biu_adro_i)
- mem_q_o  out  XLEN  read data (pass-through of biu_q_i)
- mem_ack_o, mem_err_o  out  1 each  response ok / error
- biu_stb_o  out  1  BIU request strobe
- biu_stb_ack_i  in  1  BIU accepted the address phase
- biu_adri_o  out  PLEN; biu_size_o, biu_type_o, biu_prot_o  out  3 each; biu_lock_o, biu_we_o  out  1 each; biu_d_o  out  XLEN  request fields
- biu_adro_i  in  PLEN; biu_q_i  in  XLEN; biu_ack_i, biu_err_i  in  1 each  BIU response
- err_clr_i  in  1  clear latched error (RISCV_DEXT_ERR_LATCH_EN only)
- err_valid_o  out  1; err_adr_o  out  PLEN  latched error (RISCV_DEXT_ERR_LATCH_EN only)

## Operation
- Request FIFO
  - rd/wr pointers are $clog2(QDEPTH)+1 bits wide and wrap. Full when the MSBs differ and the rest are equal; empty when the pointers are equal.
  - Head = oldest entry when not empty; otherwise it is bypassed by the live mem_* inputs.
- Issue
  - can_issue = inflight < DEPTH.
  - biu_stb_o = (~empty | mem_req_i) & can_issue & ~clr_i.
  - biu_* fields come from the head entry, or from mem_* when the FIFO is empty.
- Pop: on biu_stb_ack_i with the FIFO not empty.
- Accept
  - mem_adr_ack_o = mem_req_i & ~clr_i & (~full | pop).
  - The accepted request is written to the FIFO, except when the FIFO is empty and biu_stb_ack_i is asserted in the same cycle; that request bypasses the FIFO.
- inflight counter, $clog2(DEPTH+1) bits:
  - +1 on biu_stb_ack_i.
  - -1 on (biu_ack_i | biu_err_i).
  - Unchanged when both happen in the same cycle.
  - Never exceeds DEPTH.
- Flush (clr_i)
  - FIFO empties on the next edge; pointers are set equal.
  - discard loads inflight, or inflight-1 if a response arrives in the same cycle.
  - While discard != 0, each response decrements discard and is suppressed.
- Response
  - valid = (biu_ack_i | biu_err_i) & (inflight != 0 | biu_stb_ack_i).
  - mem_ack_o = biu_ack_i & valid & ~clr_i & (discard == 0).
  - mem_err_o uses the same terms with biu_err_i.
  - Responses with inflight == 0 and no biu_stb_ack_i are ignored.
- Locked transfers: requests are never reordered, so mem_lock_i sequences reach the BIU unchanged.

## Timing
- Reset (async): FIFO empty, inflight = 0, discard = 0, err_valid_o = 0, err_adr_o = 0.
  - While rst_ni is low, biu_stb_o, mem_adr_ack_o, mem_ack_o and mem_err_o are 0.
  - mem_rdy_o is 1 after reset.
- Latency
  - Empty FIFO with can_issue: biu_stb_o in the same cycle as mem_req_i (0 cycles).
  - Otherwise the request issues in the cycle after it becomes head and can_issue holds.
- Response paths (biu_ack_i/biu_err_i to mem_ack_o/mem_err_o) are combinational, 0 cycles.
- Reset mid-operation: all state clears immediately. Responses after reset release are ignored (inflight = 0).
- Simultaneous clr_i and mem_req_i: the request is not accepted.
- Simultaneous clr_i and a response: the response is suppressed.

## Configuration
- Macro RISCV_DEXT_ERR_LATCH_EN.
- Defined:
  - A DEPTH-entry tag FIFO holds biu_adro_i on each biu_stb_ack_i and pops on each response.
  - On the first non-discarded error while err_valid_o = 0, err_adr_o captures the popped tag and err_valid_o is set.
  - err_clr_i clears err_valid_o on the next edge; a new error in that same cycle wins and sets it again.
  - clr_i flushes the tag FIFO.
- Undefined: no tag FIFO; err_valid_o and err_adr_o tied to 0; err_clr_i ignored.

## Test plan
- Single bypass: empty FIFO, mem_req_i = 1, adr = 0x1000, biu_stb_ack_i = 1 same cycle, biu_ack_i next cycle -> biu_stb_o and mem_adr_ack_o in cycle 0, mem_ack_o in cycle 1, FIFO stays empty.
- Backpressure, DEPTH = 2, QDEPTH = 4: 6 back-to-back requests, no BIU responses -> 2 issued, 4 queued, mem_rdy_o = 0, biu_stb_o = 0; one biu_ack_i -> biu_stb_o = 1 next cycle.
- Flush: 2 in flight, 3 queued, pulse clr_i -> FIFO empty; next 2 biu_ack_i give mem_ack_o = 0; the following new request's ack gives mem_ack_o = 1.
- Flush with a same-cycle response: inflight = 2, clr_i and biu_ack_i together -> discard = 1, mem_ack_o = 0 in both response cycles.
- Counter edge: biu_stb_ack_i and biu_ack_i together for 10 cycles -> inflight constant, 10 mem_ack_o pulses.
- ERR_LATCH_EN: issue to 0x2000 then 0x3000, biu_err_i on both -> err_valid_o = 1, err_adr_o = 0x2000, mem_err_o pulses twice; err_clr_i -> err_valid_o = 0 next cycle.

Source files
------------

// File: rtl/riscv_dext_queue.sv
// rtl/riscv_dext_queue.sv - data external access queue between LSU/dcache and the AHB-Lite BIU
// Optional error-address latch: define RISCV_DEXT_ERR_LATCH_EN.
module riscv_dext_queue #(
    parameter int XLEN   = 64,
    parameter int PLEN   = 64,
    parameter int QDEPTH = 4,
    parameter int DEPTH  = 2
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            clr_i,

    input  logic            mem_req_i,
    input  logic [XLEN-1:0] mem_adr_i,
    input  logic [2:0]      mem_size_i,
    input  logic [2:0]      mem_type_i,
    input  logic [2:0]      mem_prot_i,
    input  logic            mem_lock_i,
    input  logic            mem_we_i,
    input  logic [XLEN-1:0] mem_d_i,
    output logic            mem_adr_ack_o,
    output logic            mem_rdy_o,
    output logic [PLEN-1:0] mem_adr_o,
    output logic [XLEN-1:0] mem_q_o,
    output logic            mem_ack_o,
    output logic            mem_err_o,

    output logic            biu_stb_o,
    input  logic            biu_stb_ack_i,
    output logic [PLEN-1:0] biu_adri_o,
    output logic [2:0]      biu_size_o,
    output logic [2:0]      biu_type_o,
    output logic [2:0]      biu_prot_o,
    output logic            biu_lock_o,
    output logic            biu_we_o,
    output logic [XLEN-1:0] biu_d_o,
    input  logic [PLEN-1:0] biu_adro_i,
    input  logic [XLEN-1:0] biu_q_i,
    input  logic            biu_ack_i,
    input  logic            biu_err_i,

    input  logic            err_clr_i,
    output logic            err_valid_o,
    output logic [PLEN-1:0] err_adr_o
);

    localparam int AW = $clog2(QDEPTH);
    localparam int PW = AW + 1;
    localparam int IW = $clog2(DEPTH + 1);
    localparam logic [IW-1:0] DEPTH_L = IW'(DEPTH);

    logic [XLEN-1:0] q_adr  [QDEPTH];
    logic [XLEN-1:0] q_d    [QDEPTH];
    logic [2:0]      q_size [QDEPTH];
    logic [2:0]      q_type [QDEPTH];
    logic [2:0]      q_prot [QDEPTH];
    logic            q_lock [QDEPTH];
    logic            q_we   [QDEPTH];

    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [IW-1:0] inflight, discard;
    logic          empty, full, can_issue, pop, push, accept;
    logic          resp_valid, resp_live;

    assign empty     = (rd_ptr == wr_ptr);
    assign full      = (rd_ptr[AW] != wr_ptr[AW]) && (rd_ptr[AW-1:0] == wr_ptr[AW-1:0]);
    assign can_issue = (inflight < DEPTH_L);

    assign biu_stb_o = rst_ni & (~empty | mem_req_i) & can_issue & ~clr_i;
    assign pop       = biu_stb_ack_i & ~empty;
    assign accept    = rst_ni & mem_req_i & ~clr_i & (~full | pop);
    // An empty FIFO with a same-cycle address ack means the request went straight out.
    assign push      = accept & ~(empty & biu_stb_ack_i);

    assign mem_adr_ack_o = accept;
    assign mem_rdy_o     = ~full;

    always_comb begin
        if (empty) begin
            biu_adri_o = PLEN'(mem_adr_i);
            biu_size_o = mem_size_i;
            biu_type_o = mem_type_i;
            biu_prot_o = mem_prot_i;
            biu_lock_o = mem_lock_i;
            biu_we_o   = mem_we_i;
            biu_d_o    = mem_d_i;
        end else begin
            biu_adri_o = PLEN'(q_adr[rd_ptr[AW-1:0]]);
            biu_size_o = q_size[rd_ptr[AW-1:0]];
            biu_type_o = q_type[rd_ptr[AW-1:0]];
            biu_prot_o = q_prot[rd_ptr[AW-1:0]];
            biu_lock_o = q_lock[rd_ptr[AW-1:0]];
            biu_we_o   = q_we[rd_ptr[AW-1:0]];
            biu_d_o    = q_d[rd_ptr[AW-1:0]];
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            q_adr[wr_ptr[AW-1:0]]  <= mem_adr_i;
            q_d[wr_ptr[AW-1:0]]    <= mem_d_i;
            q_size[wr_ptr[AW-1:0]] <= mem_size_i;
            q_type[wr_ptr[AW-1:0]] <= mem_type_i;
            q_prot[wr_ptr[AW-1:0]] <= mem_prot_i;
            q_lock[wr_ptr[AW-1:0]] <= mem_lock_i;
            q_we[wr_ptr[AW-1:0]]   <= mem_we_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else if (clr_i) begin
            rd_ptr <= wr_ptr;
        end else begin
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            if (push) wr_ptr <= wr_ptr + PW'(1);
        end
    end

    assign resp_valid = (biu_ack_i | biu_err_i) & ((inflight != '0) | biu_stb_ack_i);
    assign resp_live  = resp_valid & ~clr_i & (discard == '0);

    assign mem_ack_o = rst_ni & biu_ack_i & resp_live;
    assign mem_err_o = rst_ni & biu_err_i & resp_live;
    assign mem_adr_o = biu_adro_i;
    assign mem_q_o   = biu_q_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            inflight <= '0;
            discard  <= '0;
        end else begin
            case ({biu_stb_ack_i, resp_valid})
                2'b10:   if (inflight != DEPTH_L) inflight <= inflight + IW'(1);
                2'b01:   inflight <= inflight - IW'(1);
                default: inflight <= inflight;
            endcase
            // Everything still in flight at a flush belongs to dropped requests.
            if (clr_i)
                discard <= resp_valid ? inflight - IW'(1) : inflight;
            else if (resp_valid && discard != '0)
                discard <= discard - IW'(1);
        end
    end

`ifdef RISCV_DEXT_ERR_LATCH_EN
    localparam int TW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PLEN-1:0] tag_mem [DEPTH];
    logic [TW-1:0]   tag_rd, tag_wr;
    logic [IW-1:0]   tag_cnt;
    logic [PLEN-1:0] head_tag;
    logic            tag_store, err_hit;

    assign head_tag  = (tag_cnt == '0) ? biu_adro_i : tag_mem[tag_rd];
    assign tag_store = biu_stb_ack_i & ~(resp_live & (tag_cnt == '0));
    assign err_hit   = biu_err_i & resp_live;

    function automatic logic [TW-1:0] tag_next(input logic [TW-1:0] p);
        return (p == TW'(DEPTH - 1)) ? '0 : p + TW'(1);
    endfunction

    always_ff @(posedge clk_i) begin
        if (tag_store) tag_mem[tag_wr] <= biu_adro_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tag_rd  <= '0;
            tag_wr  <= '0;
            tag_cnt <= '0;
        end else if (clr_i) begin
            tag_rd  <= '0;
            tag_wr  <= '0;
            tag_cnt <= '0;
        end else begin
            if (tag_store) tag_wr <= tag_next(tag_wr);
            if (resp_live && tag_cnt != '0) tag_rd <= tag_next(tag_rd);
            case ({tag_store, resp_live})
                2'b10:   tag_cnt <= tag_cnt + IW'(1);
                2'b01:   tag_cnt <= tag_cnt - IW'(1);
                default: tag_cnt <= tag_cnt;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_valid_o <= 1'b0;
            err_adr_o   <= '0;
        end else if (err_hit && (!err_valid_o || err_clr_i)) begin
            err_valid_o <= 1'b1;
            err_adr_o   <= head_tag;
        end else if (err_clr_i) begin
            err_valid_o <= 1'b0;
        end
    end
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr_i;
    assign err_valid_o    = 1'b0;
    assign err_adr_o      = '0;
`endif

endmodule

// File: tb/tb_riscv_dext_queue.sv
// tb/tb_riscv_dext_queue.sv - directed self-checking bench for riscv_dext_queue
module tb_riscv_dext_queue;
    localparam int XLEN = 64, PLEN = 64, QDEPTH = 4, DEPTH = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_ni, clr_i, mem_req_i, mem_lock_i, mem_we_i;
    logic biu_stb_ack_i, biu_ack_i, biu_err_i, err_clr_i, ack_en;
    logic [XLEN-1:0] mem_adr_i, mem_d_i, biu_q_i, mem_q_o, biu_d_o;
    logic [PLEN-1:0] biu_adro_i, mem_adr_o, biu_adri_o, err_adr_o;
    logic [2:0] mem_size_i, mem_type_i, mem_prot_i, biu_size_o, biu_type_o, biu_prot_o;
    logic mem_adr_ack_o, mem_rdy_o, mem_ack_o, mem_err_o, biu_stb_o;
    logic biu_lock_o, biu_we_o, err_valid_o;

    assign biu_stb_ack_i = ack_en & biu_stb_o;
    assign biu_adro_i    = biu_adri_o;

    riscv_dext_queue #(.XLEN(XLEN), .PLEN(PLEN), .QDEPTH(QDEPTH), .DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .clr_i(clr_i),
        .mem_req_i(mem_req_i), .mem_adr_i(mem_adr_i), .mem_size_i(mem_size_i),
        .mem_type_i(mem_type_i), .mem_prot_i(mem_prot_i), .mem_lock_i(mem_lock_i),
        .mem_we_i(mem_we_i), .mem_d_i(mem_d_i), .mem_adr_ack_o(mem_adr_ack_o),
        .mem_rdy_o(mem_rdy_o), .mem_adr_o(mem_adr_o), .mem_q_o(mem_q_o),
        .mem_ack_o(mem_ack_o), .mem_err_o(mem_err_o),
        .biu_stb_o(biu_stb_o), .biu_stb_ack_i(biu_stb_ack_i), .biu_adri_o(biu_adri_o),
        .biu_size_o(biu_size_o), .biu_type_o(biu_type_o), .biu_prot_o(biu_prot_o),
        .biu_lock_o(biu_lock_o), .biu_we_o(biu_we_o), .biu_d_o(biu_d_o),
        .biu_adro_i(biu_adro_i), .biu_q_i(biu_q_i), .biu_ack_i(biu_ack_i),
        .biu_err_i(biu_err_i), .err_clr_i(err_clr_i), .err_valid_o(err_valid_o),
        .err_adr_o(err_adr_o)
    );

    int errors = 0, checks = 0, n_ack = 0, n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: pending requests as an address queue, counters as plain ints.
    logic [63:0] mq[$];
    logic [63:0] tq[$];
    int m_inf, m_dis, m_n;
    logic m_ev;
    logic [63:0] m_ea;
    logic e_stb, e_sack, e_full, e_acc, e_valid, e_live, e_mack, e_merr;
    logic [63:0] e_adri, e_tag;

    function automatic void model_eval();
        int n = mq.size();
        e_stb   = rst_ni && (n > 0 || mem_req_i) && m_inf < DEPTH && !clr_i;
        e_sack  = ack_en && e_stb;
        e_adri  = (n > 0) ? mq[0] : mem_adr_i;
        e_full  = (n == QDEPTH);
        e_acc   = rst_ni && mem_req_i && !clr_i && (!e_full || (e_sack && n > 0));
        e_valid = (biu_ack_i || biu_err_i) && (m_inf > 0 || e_sack);
        e_live  = rst_ni && e_valid && !clr_i && m_dis == 0;
        e_mack  = e_live && biu_ack_i;
        e_merr  = e_live && biu_err_i;
        e_tag   = (tq.size() > 0) ? tq[0] : e_adri;
    endfunction

    always @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            mq.delete(); tq.delete();
            m_inf = 0; m_dis = 0; m_ev = 1'b0; m_ea = '0;
        end else begin
            model_eval();
            m_n = mq.size();
            if (e_merr && (!m_ev || err_clr_i)) begin
                m_ev = 1'b1; m_ea = e_tag;
            end else if (err_clr_i) m_ev = 1'b0;
            if (clr_i) begin
                mq.delete(); tq.delete();
                m_dis = m_inf - (e_valid ? 1 : 0);
            end else begin
                if (e_sack) tq.push_back(e_adri);
                if (e_live) void'(tq.pop_front());
                if (e_sack && m_n > 0) void'(mq.pop_front());
                if (e_acc && !(m_n == 0 && e_sack)) mq.push_back(mem_adr_i);
                if (e_valid && m_dis > 0) m_dis--;
            end
            m_inf = m_inf + (e_sack ? 1 : 0) - (e_valid ? 1 : 0);
        end
    end

    always @(negedge clk) begin
        model_eval();
        chk("biu_stb", biu_stb_o, e_stb);
        chk("adr_ack", mem_adr_ack_o, e_acc);
        chk("rdy", mem_rdy_o, !e_full);
        chk("mem_ack", mem_ack_o, e_mack);
        chk("mem_err", mem_err_o, e_merr);
        chk("mem_q", mem_q_o, biu_q_i);
        if (e_stb) chk("biu_adri", biu_adri_o, e_adri);
`ifdef RISCV_DEXT_ERR_LATCH_EN
        chk("err_valid", err_valid_o, m_ev);
        if (m_ev) chk("err_adr", err_adr_o, m_ea);
`else
        chk("err_valid", err_valid_o, 1'b0);
        chk("err_adr", err_adr_o, 64'h0);
`endif
        if (mem_ack_o) n_ack++;
        if (mem_err_o) n_err++;
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic idle();
        mem_req_i = 0; clr_i = 0; biu_ack_i = 0; biu_err_i = 0; err_clr_i = 0; ack_en = 0;
    endtask

    task automatic req(input logic [63:0] a);
        mem_req_i = 1; mem_adr_i = a; mem_d_i = ~a;
    endtask

    int a0, e0;

    initial begin
        idle();
        mem_adr_i = '0; mem_d_i = '0; mem_size_i = 3'd3; mem_type_i = 3'd0; mem_prot_i = 3'd1;
        mem_lock_i = 0; mem_we_i = 0; biu_q_i = 64'hDEAD_BEEF_0000_0001;
        rst_ni = 0; mem_req_i = 1; ack_en = 1;
        @(negedge clk);
        chk("rst_stb", biu_stb_o, 1'b0);
        chk("rst_adr_ack", mem_adr_ack_o, 1'b0);
        chk("rst_rdy", mem_rdy_o, 1'b1);
        tick(); idle(); rst_ni = 1;

        // single bypass
        tick(); req(64'h1000); ack_en = 1;
        @(negedge clk);
        chk("t1_stb", biu_stb_o, 1'b1);
        chk("t1_adr_ack", mem_adr_ack_o, 1'b1);
        chk("t1_adri", biu_adri_o, 64'h1000);
        tick(); idle(); biu_ack_i = 1;
        @(negedge clk);
        chk("t1_ack", mem_ack_o, 1'b1);
        chk("t1_rdy", mem_rdy_o, 1'b1);
        tick(); idle();

        // backpressure: 2 issued, 4 queued
        for (int i = 0; i < 6; i++) begin
            req(64'hA000 + 64'(i * 8)); ack_en = 1; tick();
        end
        idle();
        @(negedge clk);
        chk("t2_rdy", mem_rdy_o, 1'b0);
        chk("t2_stb", biu_stb_o, 1'b0);
        tick(); biu_ack_i = 1;
        tick(); idle(); ack_en = 1;
        @(negedge clk);
        chk("t2_restb", biu_stb_o, 1'b1);
        chk("t2_head", biu_adri_o, 64'hA010);
        tick();
        for (int i = 0; i < 6; i++) begin
            ack_en = 1; biu_ack_i = 1; tick();
        end
        idle(); biu_ack_i = 1;
        @(negedge clk);
        chk("t2_stray", mem_ack_o, 1'b0);
        tick(); idle();

        // flush with 2 in flight, 3 queued
        for (int i = 0; i < 5; i++) begin
            req(64'hB000 + 64'(i * 8)); ack_en = 1; tick();
        end
        idle(); clr_i = 1;
        @(negedge clk);
        chk("t3_clr_stb", biu_stb_o, 1'b0);
        tick(); idle();
        @(negedge clk);
        chk("t3_rdy", mem_rdy_o, 1'b1);
        chk("t3_empty", biu_stb_o, 1'b0);
        for (int i = 0; i < 2; i++) begin
            tick(); idle(); biu_ack_i = 1;
            @(negedge clk);
            chk("t3_disc", mem_ack_o, 1'b0);
        end
        tick(); idle(); req(64'h5000); ack_en = 1;
        tick(); idle(); biu_ack_i = 1;
        @(negedge clk);
        chk("t3_new", mem_ack_o, 1'b1);
        tick(); idle();

        // flush with a same-cycle response
        req(64'hC000); ack_en = 1; tick();
        req(64'hC008); ack_en = 1; tick();
        idle(); clr_i = 1; biu_ack_i = 1;
        @(negedge clk);
        chk("t4_a", mem_ack_o, 1'b0);
        tick(); idle(); biu_ack_i = 1;
        @(negedge clk);
        chk("t4_b", mem_ack_o, 1'b0);
        tick(); idle();

        // simultaneous address ack and response
        a0 = n_ack;
        for (int i = 0; i < 10; i++) begin
            req(64'hD000 + 64'(i * 8)); ack_en = 1; biu_ack_i = 1; tick();
        end
        idle(); tick();
        chk("t5_pulses", 64'(n_ack - a0), 64'd10);

        // error responses
        e0 = n_err;
        req(64'h2000); ack_en = 1; tick();
        req(64'h3000); ack_en = 1; tick();
        idle(); biu_err_i = 1; tick();
        biu_err_i = 1; tick();
        idle();
        @(negedge clk);
        chk("t6_err_pulses", 64'(n_err - e0), 64'd2);
`ifdef RISCV_DEXT_ERR_LATCH_EN
        chk("t6_valid", err_valid_o, 1'b1);
        chk("t6_adr", err_adr_o, 64'h2000);
        tick(); err_clr_i = 1;
        tick(); idle();
        @(negedge clk);
        chk("t6_cleared", err_valid_o, 1'b0);
`else
        chk("t6_valid", err_valid_o, 1'b0);
`endif
        tick(); idle();

        // reset mid-operation
        req(64'hE000); ack_en = 1; tick();
        idle(); rst_ni = 0; req(64'hE008); ack_en = 1;
        #1;
        chk("t7_stb", biu_stb_o, 1'b0);
        chk("t7_adr_ack", mem_adr_ack_o, 1'b0);
        tick(); idle(); rst_ni = 1; biu_ack_i = 1;
        @(negedge clk);
        chk("t7_ack", mem_ack_o, 1'b0);
        tick(); idle(); tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
